// File: rtl/carbon_fabric_bootseq_if.sv
// Fabric initiator/target interface used by early-boot masters such as carbon_fabric_bootseq.
// Address, data and id widths are parameters; the strobe width follows the data width.
interface fabric_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    localparam int STRB_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic [ID_W-1:0]   req_id;
    logic [3:0]        req_attr;
    logic [2:0]        req_size;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_code;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_wstrb, req_id, req_attr, req_size,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_code
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_wstrb, req_id, req_attr, req_size,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_code
    );
endinterface

// File: rtl/carbon_fabric_bootseq.sv
// Scripted fabric bring-up master: runs WRITE/POLL/WAIT/END entries from an async script ROM.
// Optional CARBON_BOOTSEQ_POWEROFF_EN issues a final poweroff MMIO write before DONE.
package carbon_fabric_pkg;
    localparam logic [1:0]  CARBON_FABRIC_XACT_READ      = 2'd0;
    localparam logic [1:0]  CARBON_FABRIC_XACT_WRITE     = 2'd1;
    localparam logic [3:0]  CARBON_FABRIC_ATTR_ORDERED   = 4'b0001;
    localparam logic [3:0]  CARBON_FABRIC_ATTR_CACHEABLE = 4'b0010;
    localparam logic [31:0] CARBON_MMIO_POWEROFF_OFF     = 32'h0000_0010;

    typedef enum logic [1:0] {
        OP_END   = 2'd0,
        OP_WRITE = 2'd1,
        OP_POLL  = 2'd2,
        OP_WAIT  = 2'd3
    } op_kind_e;

    localparam logic [1:0] ERR_RSP_CODE = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_POLL     = 2'd3;
endpackage

module carbon_fabric_bootseq
    import carbon_fabric_pkg::*;
#(
    parameter int          NUM_OPS     = 16,
    parameter int          START_DELAY = 8,
    parameter int          RSP_TIMEOUT = 256,
    parameter int          POLL_LIMIT  = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0,
    localparam int         IDX_W       = $clog2(NUM_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    fabric_if.master         fab,
    output logic [IDX_W-1:0] op_idx,
    input  logic [1:0]       op_kind,
    input  logic [31:0]      op_addr,
    input  logic [31:0]      op_data,
    input  logic [31:0]      op_mask,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [IDX_W-1:0] err_idx
);
    localparam int FAB_ADDR_W = $bits(fab.req_addr);
    localparam int FAB_DATA_W = $bits(fab.req_wdata);
    localparam int FAB_STRB_W = $bits(fab.req_wstrb);
    localparam int DLY_W  = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);
    localparam int TO_W   = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        ST_DELAY, ST_FETCH, ST_REQ, ST_RSP, ST_WAIT, ST_FINISH, ST_DONE, ST_ERR
    } state_e;

    state_e              state;
    logic [DLY_W-1:0]    dly_cnt;
    op_kind_e            kind_q;
    logic [31:0]         data_q;
    logic [31:0]         mask_q;
    logic [POLL_W-1:0]   poll_cnt;
    logic [TO_W-1:0]     tmo_cnt;
    logic [31:0]         wait_cnt;
    op_kind_e            fetch_kind;
    logic                poll_match;
    logic [IDX_W-1:0]    fail_idx;
    logic [FAB_DATA_W-1:0] poll_mask;

`ifdef CARBON_BOOTSEQ_POWEROFF_EN
    localparam logic [31:0] PWR_ADDR = MMIO_BASE + CARBON_MMIO_POWEROFF_OFF;
    logic pwr_q;
`endif

    assign fab.rsp_ready = 1'b1;
    assign fab.req_id    = '0;
    assign fab.req_attr  = CARBON_FABRIC_ATTR_ORDERED | CARBON_FABRIC_ATTR_CACHEABLE;
    assign fab.req_size  = 3'd0;

    always_comb begin
        fetch_kind = (op_idx == IDX_W'(NUM_OPS)) ? OP_END : op_kind_e'(op_kind);
        poll_mask  = FAB_DATA_W'(mask_q);
        poll_match = (fab.rsp_rdata & poll_mask) == (FAB_DATA_W'(data_q) & poll_mask);
`ifdef CARBON_BOOTSEQ_POWEROFF_EN
        fail_idx   = pwr_q ? IDX_W'(NUM_OPS) : op_idx;
`else
        fail_idx   = op_idx;
`endif
    end

    // NOTE: every register here, script captures included, is cleared by the async reset so a
    // mid-transaction reset drops the request at once instead of leaving stale state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_DELAY;
            dly_cnt       <= DLY_W'(START_DELAY);
            op_idx        <= '0;
            kind_q        <= OP_END;
            data_q        <= '0;
            mask_q        <= '0;
            poll_cnt      <= '0;
            tmo_cnt       <= '0;
            wait_cnt      <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= '0;
            err_idx       <= '0;
            fab.req_valid <= 1'b0;
            fab.req_op    <= CARBON_FABRIC_XACT_READ;
            fab.req_addr  <= '0;
            fab.req_wdata <= '0;
            fab.req_wstrb <= '0;
`ifdef CARBON_BOOTSEQ_POWEROFF_EN
            pwr_q         <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge values.
            case (state)
                ST_DELAY: begin
                    if (dly_cnt == '0) state <= ST_FETCH;
                    else               dly_cnt <= dly_cnt - 1'b1;
                end

                ST_FETCH: begin
                    kind_q <= fetch_kind;
                    data_q <= op_data;
                    mask_q <= op_mask;
                    case (fetch_kind)
                        OP_END: state <= ST_FINISH;
                        OP_WRITE: begin
                            fab.req_valid <= 1'b1;
                            fab.req_op    <= CARBON_FABRIC_XACT_WRITE;
                            fab.req_addr  <= op_addr[FAB_ADDR_W-1:0];
                            fab.req_wdata <= FAB_DATA_W'(op_data);
                            fab.req_wstrb <= op_mask[FAB_STRB_W-1:0];
                            state         <= ST_REQ;
                        end
                        OP_POLL: begin
                            fab.req_valid <= 1'b1;
                            fab.req_op    <= CARBON_FABRIC_XACT_READ;
                            fab.req_addr  <= op_addr[FAB_ADDR_W-1:0];
                            fab.req_wdata <= '0;
                            fab.req_wstrb <= '0;
                            poll_cnt      <= '0;
                            state         <= ST_REQ;
                        end
                        OP_WAIT: begin
                            wait_cnt <= op_data;
                            state    <= ST_WAIT;
                        end
                    endcase
                end

                ST_REQ: begin
                    if (fab.req_ready) begin
                        fab.req_valid <= 1'b0;
                        tmo_cnt       <= '0;
                        state         <= ST_RSP;
                    end
                end

                // A response always takes priority over the timeout in the same cycle.
                ST_RSP: begin
                    if (fab.rsp_valid) begin
                        if (fab.rsp_code != 2'd0) begin
                            state    <= ST_ERR;
                            error    <= 1'b1;
                            err_code <= ERR_RSP_CODE;
                            err_idx  <= fail_idx;
                        end else if (kind_q == OP_WRITE || poll_match) begin
`ifdef CARBON_BOOTSEQ_POWEROFF_EN
                            if (pwr_q) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                op_idx <= op_idx + 1'b1;
                                state  <= ST_FETCH;
                            end
`else
                            op_idx <= op_idx + 1'b1;
                            state  <= ST_FETCH;
`endif
                        end else if (poll_cnt == POLL_W'(POLL_LIMIT - 1)) begin
                            state    <= ST_ERR;
                            error    <= 1'b1;
                            err_code <= ERR_POLL;
                            err_idx  <= fail_idx;
                        end else begin
                            poll_cnt      <= poll_cnt + 1'b1;
                            fab.req_valid <= 1'b1;
                            state         <= ST_REQ;
                        end
                    end else if (RSP_TIMEOUT != 0) begin
                        if (tmo_cnt == TO_W'(RSP_TIMEOUT - 1)) begin
                            state    <= ST_ERR;
                            error    <= 1'b1;
                            err_code <= ERR_TIMEOUT;
                            err_idx  <= fail_idx;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        op_idx <= op_idx + 1'b1;
                        state  <= ST_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                ST_FINISH: begin
`ifdef CARBON_BOOTSEQ_POWEROFF_EN
                    kind_q        <= OP_WRITE;
                    pwr_q         <= 1'b1;
                    fab.req_valid <= 1'b1;
                    fab.req_op    <= CARBON_FABRIC_XACT_WRITE;
                    fab.req_addr  <= PWR_ADDR[FAB_ADDR_W-1:0];
                    fab.req_wdata <= FAB_DATA_W'(32'h1);
                    fab.req_wstrb <= FAB_STRB_W'(1);
                    state         <= ST_REQ;
`else
                    done  <= 1'b1;
                    state <= ST_DONE;
`endif
                end

                ST_DONE: state <= ST_DONE;
                ST_ERR:  state <= ST_ERR;
            endcase
        end
    end
endmodule
